// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Fetch-stage PC controller with handshaked, stall-aware fetch
//             sequencing against variable-latency instruction memory.
//             FETCH_DELAY_SLOT_EN selects MIPS branch-delay-slot redirects.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
   parameter int                  PC_WIDTH = 32,
   parameter int                  PC_STEP  = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                br_en,
   input  logic [PC_WIDTH-1:0] br_addr,
   input  logic                rom_ack,
   output logic [PC_WIDTH-1:0] pc,
   output logic                romCe,
   output logic                fetch_valid,
   output logic [PC_WIDTH-1:0] fetch_pc
);

   localparam logic [1:0]          C_BOOT = 2'd0;
   localparam logic [1:0]          C_REQ  = 2'd1;
   localparam logic [1:0]          C_HOLD = 2'd2;
   localparam logic [PC_WIDTH-1:0] C_STEP = PC_WIDTH'(PC_STEP);

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic                w_accept;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [PC_WIDTH-1:0] w_fetch_pc_nxt;
   logic                w_fv_nxt;
   logic                w_ce_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= C_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Every legal state leaves toward REQ unless the pipeline is stalled.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_BOOT,
         C_REQ,
         C_HOLD:  w_state_nxt = stall ? C_HOLD : C_REQ;
         default: w_state_nxt = C_BOOT;
      endcase
   end

`ifdef FETCH_DELAY_SLOT_EN
   logic                r_pend;
   logic [PC_WIDTH-1:0] r_tgt;

   // The delay slot is never squashed; a redirect only steers the next PC.
   assign w_accept = (r_state == C_REQ) && rom_ack && !stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= 1'b0;
         r_tgt  <= '0;
      end else begin
         if (br_en) begin
            r_tgt <= br_addr;
         end
         if (w_accept) begin
            r_pend <= 1'b0;
         end else if (br_en) begin
            r_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      w_pc_nxt = pc;
      if (w_accept) begin
         if (br_en) begin
            w_pc_nxt = br_addr;
         end else if (r_pend) begin
            w_pc_nxt = r_tgt;
         end else begin
            w_pc_nxt = pc + C_STEP;
         end
      end
   end
`else
   // A redirect squashes whatever the memory returns in the same cycle.
   assign w_accept = (r_state == C_REQ) && rom_ack && !stall && !br_en;

   always_comb begin
      w_pc_nxt = pc;
      if (br_en) begin
         w_pc_nxt = br_addr;
      end else if (w_accept) begin
         w_pc_nxt = pc + C_STEP;
      end
   end
`endif

   always_comb begin
      w_fv_nxt       = w_accept;
      w_fetch_pc_nxt = w_accept ? pc : fetch_pc;
      w_ce_nxt       = (w_state_nxt == C_REQ);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         romCe       <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_pc    <= '0;
      end else begin
         pc          <= w_pc_nxt;
         romCe       <= w_ce_nxt;
         fetch_valid <= w_fv_nxt;
         fetch_pc    <= w_fetch_pc_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Vector table plus delivery scoreboard for fetch_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

   typedef struct {
      logic        stall;
      logic        br_en;
      logic [31:0] br_addr;
      logic        ack;
      logic [31:0] pc;
      logic        ce;
      logic        fv;
      logic        push;
      logic [31:0] push_pc;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_en;
   logic [31:0] br_addr;
   logic        rom_ack;
   logic [31:0] pc;
   logic        romCe;
   logic        fetch_valid;
   logic [31:0] fetch_pc;

   logic        n_stall;
   logic        n_br_en;
   logic [7:0]  n_br_addr;
   logic        n_ack;
   logic [7:0]  n_pc;
   logic        n_ce;
   logic        n_fv;
   logic [7:0]  n_fetch_pc;

   int          checks;
   int          failures;
   vec_t        tbl[$];
   logic [31:0] sb[$];

   fetch_sequencer #(.PC_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_addr(br_addr),
      .rom_ack(rom_ack), .pc(pc), .romCe(romCe), .fetch_valid(fetch_valid),
      .fetch_pc(fetch_pc)
   );

   // Narrow instance starting near the top of its address space.
   fetch_sequencer #(.PC_WIDTH(8), .PC_STEP(4), .RESET_PC(8'hFC)) dut8 (
      .clk(clk), .rst(rst), .stall(n_stall), .br_en(n_br_en), .br_addr(n_br_addr),
      .rom_ack(n_ack), .pc(n_pc), .romCe(n_ce), .fetch_valid(n_fv),
      .fetch_pc(n_fetch_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic row(input logic s, input logic b, input logic [31:0] ba, input logic a,
                      input logic [31:0] epc, input logic ece, input logic efv,
                      input logic p, input logic [31:0] ppc);
      vec_t v;
      v = '{s, b, ba, a, epc, ece, efv, p, ppc};
      tbl.push_back(v);
   endtask

   task automatic apply(input int idx, input bit first);
      vec_t        v;
      logic [31:0] e;
      v       = tbl[idx];
      stall   = v.stall;
      br_en   = v.br_en;
      br_addr = v.br_addr;
      rom_ack = v.ack;
      if (v.push) sb.push_back(v.push_pc);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_pc", idx), pc, v.pc);
      chk($sformatf("row%0d_romCe", idx), {31'b0, romCe}, {31'b0, v.ce});
      chk($sformatf("row%0d_fetch_valid", idx), {31'b0, fetch_valid}, {31'b0, v.fv});
      if (fetch_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL row%0d_unexpected_delivery fetch_pc=%h", idx, fetch_pc);
         end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d_fetch_pc", idx), fetch_pc, e);
         end
      end
      if (first && idx == 0) begin
         chk("wrap_boot_pc", {24'b0, n_pc}, 32'hFC);
         chk("wrap_boot_romCe", {31'b0, n_ce}, 32'h1);
      end
      if (first && idx == 1) begin
         chk("wrap_pc", {24'b0, n_pc}, 32'h00);
         chk("wrap_fetch_valid", {31'b0, n_fv}, 32'h1);
         chk("wrap_fetch_pc", {24'b0, n_fetch_pc}, 32'hFC);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      stall     = 1'b0;
      br_en     = 1'b0;
      br_addr   = '0;
      rom_ack   = 1'b0;
      n_stall   = 1'b0;
      n_br_en   = 1'b0;
      n_br_addr = '0;
      n_ack     = 1'b1;

      //   stall br  addr        ack  pc          ce   fv   push pushpc
      row(0, 0, 32'h0,   1, 32'h000, 1, 0, 0, 32'h0);    // BOOT -> REQ
      row(0, 0, 32'h0,   1, 32'h004, 1, 1, 1, 32'h000);
      row(0, 0, 32'h0,   1, 32'h008, 1, 1, 1, 32'h004);
      row(0, 0, 32'h0,   0, 32'h008, 1, 0, 0, 32'h0);    // wait states
      row(0, 0, 32'h0,   0, 32'h008, 1, 0, 0, 32'h0);
      row(0, 0, 32'h0,   0, 32'h008, 1, 0, 0, 32'h0);
      row(0, 0, 32'h0,   1, 32'h00C, 1, 1, 1, 32'h008);
      row(1, 0, 32'h0,   1, 32'h00C, 0, 0, 0, 32'h0);    // stall wins over ack
      row(1, 0, 32'h0,   1, 32'h00C, 0, 0, 0, 32'h0);
      row(0, 0, 32'h0,   1, 32'h00C, 1, 0, 0, 32'h0);    // ack in HOLD ignored
      row(0, 0, 32'h0,   1, 32'h010, 1, 1, 1, 32'h00C);
`ifdef FETCH_DELAY_SLOT_EN
      row(0, 1, 32'h100, 1, 32'h100, 1, 1, 1, 32'h010);
      row(0, 0, 32'h0,   1, 32'h104, 1, 1, 1, 32'h100);
      row(0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 32'h0);
      row(1, 1, 32'h040, 1, 32'h104, 0, 0, 0, 32'h0);
      row(0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 32'h0);
      row(0, 0, 32'h0,   1, 32'h040, 1, 1, 1, 32'h104);
`else
      row(0, 1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0);
      row(0, 0, 32'h0,   1, 32'h104, 1, 1, 1, 32'h100);
      row(0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 32'h0);
      row(1, 1, 32'h040, 1, 32'h040, 0, 0, 0, 32'h0);
      row(0, 0, 32'h0,   0, 32'h040, 1, 0, 0, 32'h0);
      row(0, 0, 32'h0,   0, 32'h040, 1, 0, 0, 32'h0);
`endif
      row(0, 0, 32'h0,   0, 32'h040, 1, 0, 0, 32'h0);

      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_romCe", {31'b0, romCe}, 32'h0);
      chk("reset_fetch_valid", {31'b0, fetch_valid}, 32'h0);
      chk("reset_fetch_pc", fetch_pc, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(i, 1'b1);

      // Asynchronous reset in the middle of a wait state.
      rom_ack = 1'b1;
      #3 rst = 1'b0;
      #1;
      chk("midwait_pc", pc, 32'h0);
      chk("midwait_romCe", {31'b0, romCe}, 32'h0);
      chk("midwait_fetch_valid", {31'b0, fetch_valid}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("inreset_fetch_valid", {31'b0, fetch_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) apply(i, 1'b0);

      chk("scoreboard_drained", sb.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
